// File: rtl/autosa_cvt_pkg.sv
// Shared types and constants for the accumulator output-conversion path.
package autosa_cvt_pkg;

  localparam int ACC_W = 49;
  localparam int RES_W = 32;
  localparam int SH_W  = 6;
  localparam int CNT_W = 32;

  typedef logic signed [ACC_W-1:0] acc_t;
  typedef logic signed [RES_W-1:0] res_t;

  localparam res_t RES_MAX = 32'sh7FFF_FFFF;
  localparam res_t RES_MIN = 32'sh8000_0000;

endpackage

// File: rtl/autosa_saturate.sv
// Generic signed saturate cell: clamps a signed IN_WIDTH value to signed OUT_WIDTH.
module autosa_saturate #(
  parameter int IN_WIDTH  = 50,
  parameter int OUT_WIDTH = 32
) (
  input  logic signed [IN_WIDTH-1:0]  din,
  output logic signed [OUT_WIDTH-1:0] dout,
  output logic                        sat
);

  localparam logic [OUT_WIDTH-1:0] POS_CLAMP = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] NEG_CLAMP = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  logic [IN_WIDTH-OUT_WIDTH:0] top_bits_s;
  logic                        in_range_s;

  // In range exactly when the bits above the result sign all equal that sign.
  always_comb begin
    top_bits_s = din[IN_WIDTH-1:OUT_WIDTH-1];
    in_range_s = (&top_bits_s) | ~(|top_bits_s);
    if (in_range_s) begin
      sat  = 1'b0;
      dout = din[OUT_WIDTH-1:0];
    end else if (din[IN_WIDTH-1]) begin
      sat  = 1'b1;
      dout = NEG_CLAMP;
    end else begin
      sat  = 1'b1;
      dout = POS_CLAMP;
    end
  end

endmodule

// File: rtl/autosa_acc_shift_round_sat.sv
// Accumulator output stage: arithmetic shift, round half-up, saturate; two-stage valid/ready pipe.
// Optional saturation counter enabled by macro AUTOSA_SAT_CNT_EN.
module autosa_acc_shift_round_sat
  import autosa_cvt_pkg::*;
#(
  parameter int IN_WIDTH  = ACC_W,
  parameter int OUT_WIDTH = RES_W,
  parameter int SH_WIDTH  = SH_W
) (
  input  logic                        autosa_core_clk,
  input  logic                        autosa_core_rstn,
  input  logic [SH_WIDTH-1:0]         cfg_shift,
  input  logic                        cfg_sat_cnt_clr,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [IN_WIDTH-1:0]  in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic                        out_sat,
  output logic [CNT_W-1:0]            sat_cnt
);

  localparam int RW = IN_WIDTH + 1;
  localparam logic [SH_WIDTH-1:0] SH_MAX = SH_WIDTH'(IN_WIDTH - 1);

  logic [SH_WIDTH-1:0]         sh_s;
  logic signed [RW-1:0]        x_s;
  logic signed [RW-1:0]        r_s;
  logic                        rnd_bit_s;
  logic signed [RW-1:0]        s1_r_r;
  logic                        s1_vld_r;
  logic                        s2_vld_r;
  logic                        s2_adv_s;
  logic                        in_ready_s;
  logic signed [OUT_WIDTH-1:0] sat_data_s;
  logic                        sat_flag_s;
  logic signed [OUT_WIDTH-1:0] out_data_r;
  logic                        out_sat_r;

  // Pipeline advance: s2 frees when empty or drained, s1 frees when empty or moving on.
  always_comb begin
    s2_adv_s   = ~s2_vld_r | out_ready;
    in_ready_s = ~s1_vld_r | s2_adv_s;
  end

  // S1 datapath; one extra bit keeps the rounding carry of the largest positive input.
  always_comb begin
    x_s = {in_data[IN_WIDTH-1], in_data};
    if (cfg_shift > SH_MAX) begin
      sh_s = SH_MAX;
    end else begin
      sh_s = cfg_shift;
    end
    if (sh_s == {SH_WIDTH{1'b0}}) begin
      rnd_bit_s = 1'b0;
      r_s       = x_s;
    end else begin
      rnd_bit_s = x_s[sh_s - SH_WIDTH'(1)];
      r_s       = (x_s >>> sh_s) + $signed({{IN_WIDTH{1'b0}}, rnd_bit_s});
    end
  end

  // S1 register.
  always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
    if (!autosa_core_rstn) begin
      s1_vld_r <= 1'b0;
      s1_r_r   <= {RW{1'b0}};
    end else if (in_ready_s) begin
      s1_vld_r <= in_valid;
      if (in_valid) begin
        s1_r_r <= r_s;
      end
    end
  end

  autosa_saturate #(
    .IN_WIDTH (RW),
    .OUT_WIDTH(OUT_WIDTH)
  ) u_sat (
    .din (s1_r_r),
    .dout(sat_data_s),
    .sat (sat_flag_s)
  );

  // S2 register; holds result and flag stable while stalled.
  always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
    if (!autosa_core_rstn) begin
      s2_vld_r   <= 1'b0;
      out_data_r <= {OUT_WIDTH{1'b0}};
      out_sat_r  <= 1'b0;
    end else if (s2_adv_s) begin
      s2_vld_r <= s1_vld_r;
      if (s1_vld_r) begin
        out_data_r <= sat_data_s;
        out_sat_r  <= sat_flag_s;
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = s2_vld_r;
  assign out_data  = out_data_r;
  assign out_sat   = out_sat_r;

`ifdef AUTOSA_SAT_CNT_EN
  logic [CNT_W-1:0] sat_cnt_r;

  // Clamped-beat counter; clear beats a same-cycle increment, saturates at all-ones.
  always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
    if (!autosa_core_rstn) begin
      sat_cnt_r <= {CNT_W{1'b0}};
    end else if (cfg_sat_cnt_clr) begin
      sat_cnt_r <= {CNT_W{1'b0}};
    end else if (s2_vld_r && out_ready && out_sat_r && !(&sat_cnt_r)) begin
      sat_cnt_r <= sat_cnt_r + CNT_W'(1);
    end else begin
      sat_cnt_r <= sat_cnt_r;
    end
  end

  assign sat_cnt = sat_cnt_r;
`else
  logic unused_clr_s;

  assign unused_clr_s = cfg_sat_cnt_clr;
  assign sat_cnt      = 32'h0000_0000;
`endif

endmodule
